dmem_responder: RTL and testbench

Data-memory responder for the single-cycle RISC-V core's load/store port. It serves word reads combinationally in the same cycle and commits stores on the clock edge. It also decodes a small memory-mapped I/O window: an LED register, a free-running cycle counter and a halt/"tohost" register. The halt register lets test programs signal completion to the bench.

---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_ram.sv | 21 ++
 rtl/dmem_responder.sv | 110 +++++++++++
 tb/tb_dmem_responder.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared decode constants and types for the data-memory responder.
package dmem_pkg;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h0000_1000;

  localparam logic [1:0] OFF_LED    = 2'd0;
  localparam logic [1:0] OFF_CYCLE  = 2'd1;
  localparam logic [1:0] OFF_TOHOST = 2'd2;

  typedef enum logic [1:0] {
    TGT_RAM,
    TGT_MMIO_LED,
    TGT_MMIO_CYCLE,
    TGT_MMIO_TOHOST
  } dmem_target_e;

endpackage

// File: rtl/dmem_ram.sv
// Word-addressed data RAM: asynchronous read, synchronous write, no reset.
module dmem_ram #(
  parameter  int MEM_WORDS = 64,
  localparam int AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder for the single-cycle core: RAM plus an MMIO window
// holding the LED register, a free-running cycle counter and TOHOST/halt.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          MEM_WORDS = 64,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [7:0]  Led,
  output logic        Halt,
  output logic [31:0] HaltCode
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [7:0]   led_q, led_d;
  logic         halt_q, halt_d;
  logic [31:0]  code_q, code_d;
  logic [31:0]  cycle_q, cycle_d;
  logic         sel_mmio;
  logic [1:0]   mmio_off;
  dmem_target_e target;
  logic         wr_en;
  logic         ram_we;
  logic [31:0]  ram_rdata;
  logic         unused_byte_bits;

  assign sel_mmio         = (DataAdr[31:4] == MMIO_BASE[31:4]);
  assign mmio_off         = DataAdr[3:2];
  assign wr_en            = MemWrite && !halt_q;
  assign ram_we           = wr_en && !sel_mmio;
  assign unused_byte_bits = ^DataAdr[1:0];

  // Reserved offset decodes to TGT_RAM; sel_mmio keeps it away from the RAM.
  always_comb begin
    target = TGT_RAM;
    if (sel_mmio) begin
      case (mmio_off)
        OFF_LED:    target = TGT_MMIO_LED;
        OFF_CYCLE:  target = TGT_MMIO_CYCLE;
        OFF_TOHOST: target = TGT_MMIO_TOHOST;
        default:    target = TGT_RAM;
      endcase
    end
  end

  always_comb begin
    led_d   = led_q;
    halt_d  = halt_q;
    code_d  = code_q;
    cycle_d = halt_q ? cycle_q : cycle_q + 32'd1;
    if (wr_en) begin
      case (target)
        TGT_MMIO_LED: led_d = WriteData[7:0];
        TGT_MMIO_TOHOST: begin
          if (WriteData != 32'd0) begin
            halt_d = 1'b1;
            code_d = WriteData;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_q   <= 8'd0;
      halt_q  <= 1'b0;
      code_q  <= 32'd0;
      cycle_q <= 32'd0;
    end else begin
      led_q   <= led_d;
      halt_q  <= halt_d;
      code_q  <= code_d;
      cycle_q <= cycle_d;
    end
  end

  dmem_ram #(.MEM_WORDS(MEM_WORDS)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (DataAdr[AW+1:2]),
    .wdata_i (WriteData),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    ReadData = ram_rdata;
    if (sel_mmio) begin
      case (target)
        TGT_MMIO_LED:    ReadData = {24'd0, led_q};
        TGT_MMIO_CYCLE:  ReadData = cycle_q;
        TGT_MMIO_TOHOST: ReadData = code_q;
        default:         ReadData = 32'd0;
      endcase
    end
  end

  assign Led      = led_q;
  assign Halt     = halt_q;
  assign HaltCode = code_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM, MMIO, counter wrap, halt and async reset.
module tb_dmem_responder;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk       = 1'b0;
  logic        reset     = 1'b0;
  logic        MemWrite  = 1'b0;
  logic [31:0] DataAdr   = 32'd0;
  logic [31:0] WriteData = 32'd0;
  logic [31:0] ReadData;
  logic [7:0]  Led;
  logic        Halt;
  logic [31:0] HaltCode;

  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  int          r0;
  int          w0;
  logic [31:0] frozen;

  dmem_responder #(.MEM_WORDS(64), .MMIO_BASE(BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Led       (Led),
    .Halt      (Halt),
    .HaltCode  (HaltCode)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
    $display("vec %0d %s: observed %08h expected %08h", vectors, tag, obs, exp);
  endtask

  // Apply one bus cycle at the falling edge; outputs settle 1 time unit later.
  task automatic drive(input logic we, input logic [31:0] adr, input logic [31:0] wd);
    @(negedge clk);
    MemWrite  = we;
    DataAdr   = adr;
    WriteData = wd;
    #1;
  endtask

  initial begin
    // Reset held: MMIO reads reflect cleared state.
    drive(1'b0, BASE + 32'd4, 32'd0);
    check("rst_cycle", ReadData, 32'd0);
    check("rst_led", {24'd0, Led}, 32'd0);
    check("rst_halt", {31'd0, Halt}, 32'd0);
    drive(1'b0, BASE + 32'd8, 32'd0);
    check("rst_tohost_rd", ReadData, 32'd0);

    // Release, idle 5 edges, read counter.
    drive(1'b0, BASE + 32'd4, 32'd0);
    reset = 1'b1;
    r0    = cyc;
    repeat (5) drive(1'b0, BASE + 32'd4, 32'd0);
    check("idle5_cycle", ReadData, 32'd5);
    check("idle5_led", {24'd0, Led}, 32'd0);
    check("idle5_halt", {31'd0, Halt}, 32'd0);

    // RAM store, same-cycle old data, next-cycle new data, aliasing.
    drive(1'b1, 32'h0000_0010, 32'h1234_5678);
    drive(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    check("ram_same_cycle_old", ReadData, 32'h1234_5678);
    drive(1'b0, 32'h0000_0010, 32'd0);
    check("ram_new", ReadData, 32'hDEAD_BEEF);
    drive(1'b0, 32'h0000_0110, 32'd0);
    check("ram_alias", ReadData, 32'hDEAD_BEEF);
    drive(1'b0, 32'h0000_0013, 32'd0);
    check("ram_byte_bits", ReadData, 32'hDEAD_BEEF);
    drive(1'b1, 32'h0000_0014, 32'h0BAD_F00D);
    drive(1'b0, 32'h0000_0014, 32'd0);
    check("ram_neighbor", ReadData, 32'h0BAD_F00D);
    drive(1'b0, 32'h0000_0010, 32'd0);
    check("ram_kept", ReadData, 32'hDEAD_BEEF);

    // LED register.
    drive(1'b1, BASE, 32'h0000_01A5);
    check("led_before_edge", {24'd0, Led}, 32'd0);
    drive(1'b0, BASE, 32'd0);
    check("led_out", {24'd0, Led}, 32'h0000_00A5);
    check("led_rd", ReadData, 32'h0000_00A5);

    // Stores to CYCLE and reserved offset are ignored.
    drive(1'b1, BASE + 32'd4, 32'd0);
    drive(1'b0, BASE + 32'd4, 32'd0);
    check("cycle_wr_ignored", ReadData, 32'(cyc - r0));
    drive(1'b1, BASE + 32'd12, 32'hFFFF_FFFF);
    drive(1'b0, BASE + 32'd12, 32'd0);
    check("rsvd_rd", ReadData, 32'd0);
    check("rsvd_led_kept", {24'd0, Led}, 32'h0000_00A5);
    check("rsvd_halt_kept", {31'd0, Halt}, 32'd0);

    // Counter wrap.
    @(negedge clk);
    MemWrite = 1'b0;
    DataAdr  = BASE + 32'd4;
    force dut.cycle_q = 32'hFFFF_FFFE;
    #1;
    release dut.cycle_q;
    #1;
    check("wrap_preload", ReadData, 32'hFFFF_FFFE);
    drive(1'b0, BASE + 32'd4, 32'd0);
    check("wrap_ffff", ReadData, 32'hFFFF_FFFF);
    drive(1'b0, BASE + 32'd4, 32'd0);
    check("wrap_zero", ReadData, 32'd0);
    drive(1'b0, BASE + 32'd4, 32'd0);
    check("wrap_one", ReadData, 32'd1);
    w0 = cyc;

    // TOHOST: zero write ignored, nonzero write halts.
    drive(1'b1, BASE + 32'd8, 32'd0);
    drive(1'b0, BASE + 32'd8, 32'd0);
    check("tohost0_halt", {31'd0, Halt}, 32'd0);
    check("tohost0_code", HaltCode, 32'd0);
    drive(1'b1, BASE + 32'd8, 32'd1);
    check("tohost1_halt_pre", {31'd0, Halt}, 32'd0);
    frozen = 32'd1 + 32'(cyc - w0) + 32'd1;
    drive(1'b0, BASE + 32'd4, 32'd0);
    check("tohost1_halt", {31'd0, Halt}, 32'd1);
    check("tohost1_code", HaltCode, 32'd1);
    check("freeze_first", ReadData, frozen);
    drive(1'b0, BASE + 32'd4, 32'd0);
    check("freeze_held", ReadData, frozen);

    // Stores suppressed while halted; loads still work.
    drive(1'b1, 32'h0000_0010, 32'h0000_0055);
    drive(1'b1, BASE, 32'h0000_0055);
    drive(1'b1, BASE + 32'd8, 32'd2);
    drive(1'b0, 32'h0000_0010, 32'd0);
    check("halt_ram_kept", ReadData, 32'hDEAD_BEEF);
    check("halt_led_kept", {24'd0, Led}, 32'h0000_00A5);
    check("halt_code_kept", HaltCode, 32'd1);
    drive(1'b0, BASE + 32'd8, 32'd0);
    check("halt_tohost_rd", ReadData, 32'd1);

    // Asynchronous reset in the middle of the low phase.
    @(negedge clk);
    MemWrite = 1'b0;
    DataAdr  = BASE + 32'd4;
    #2;
    reset = 1'b0;
    #1;
    check("areset_halt", {31'd0, Halt}, 32'd0);
    check("areset_code", HaltCode, 32'd0);
    check("areset_led", {24'd0, Led}, 32'd0);
    check("areset_cycle", ReadData, 32'd0);
    DataAdr = 32'h0000_0010;
    #1;
    check("areset_ram_kept", ReadData, 32'hDEAD_BEEF);
    drive(1'b0, BASE + 32'd4, 32'd0);
    check("areset_cycle_held", ReadData, 32'd0);
    reset = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
